// File: rtl/w_wb_arbiter_pkg.sv
// Shared types and constants for the W-stage writeback arbiter.
package w_wb_arbiter_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         A3_W     = 5;

  // a3 sits in the MSBs so the FIFO can expose per-entry tags by slicing the top bits
  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/w_wb_arbiter_if.sv
// Bundle of pipeline, MDU and GRF-side signals of the writeback arbiter.
interface w_wb_arbiter_if #(
  parameter int DEPTH = 2
);
  logic                     m_we;
  logic [4:0]               m_a3;
  logic [31:0]              m_wd;
  logic [31:0]              m_pc;
  logic                     mdu_valid;
  logic                     mdu_ready;
  logic [4:0]               mdu_a3;
  logic [31:0]              mdu_wd;
  logic [31:0]              mdu_pc;
  logic                     grf_we;
  logic [4:0]               grf_a3;
  logic [31:0]              grf_wd;
  logic [31:0]              grf_pc;
  logic [31:0]              pend_mask;
  logic                     stall_req;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport slave (
    input  m_we, m_a3, m_wd, m_pc, mdu_valid, mdu_a3, mdu_wd, mdu_pc,
    output mdu_ready, grf_we, grf_a3, grf_wd, grf_pc, pend_mask, stall_req, fifo_count
  );

  modport master (
    output m_we, m_a3, m_wd, m_pc, mdu_valid, mdu_a3, mdu_wd, mdu_pc,
    input  mdu_ready, grf_we, grf_a3, grf_wd, grf_pc, pend_mask, stall_req, fifo_count
  );
endinterface

// File: rtl/w_wb_arbiter_fifo.sv
// Synchronous FIFO for MDU results; exposes per-slot valid bits and tags
// (top TAG_W bits of each entry) so the parent can build a pending mask.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 69,
  parameter int TAG_W = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [W-1:0]                  din,
  output logic [W-1:0]                  head,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][TAG_W-1:0]   ent_tag
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  // storage array, written on push; contents need no reset since cnt gates validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

  // a slot is live when its distance from the read pointer is below the count
  always_comb begin
    logic [PW-1:0] offs;
    offs      = '0;
    ent_valid = '0;
    ent_tag   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs         = PW'(i) - rd_ptr;
      ent_valid[i] = ({1'b0, offs} < cnt);
      ent_tag[i]   = mem[i][W-1 -: TAG_W];
    end
  end

endmodule

// File: rtl/w_wb_arbiter.sv
// W-stage writeback arbiter: pipeline results win, MDU results queue in a FIFO
// and drain in idle slots; a saturating head-age counter requests a stall.
module w_wb_arbiter
  import w_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  w_wb_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]             count;
  wb_entry_t                 head;
  wb_entry_t                 entry_in;
  logic [DEPTH-1:0]          ent_valid;
  logic [DEPTH-1:0][A3_W-1:0] ent_a3;
  logic                      m_req;
  logic                      ready;
  logic                      push;
  logic                      pop;
  logic [AW-1:0]             age;
  logic [AW-1:0]             age_next;
  logic [31:0]               pmask;

  assign m_req    = bus.m_we && (bus.m_a3 != REG_ZERO);
  // ready looks only at the registered count; a slot freed this cycle is not reused until next
  assign ready    = (count < CW'(DEPTH)) && !reset;
  assign push     = bus.mdu_valid && ready && (bus.mdu_a3 != REG_ZERO);
  assign pop      = !m_req && (count != '0);
  assign entry_in = '{a3: bus.mdu_a3, wd: bus.mdu_wd, pc: bus.mdu_pc};

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W),
    .TAG_W (A3_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (entry_in),
    .head      (head),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_tag   (ent_a3)
  );

  // output register: pipeline first, then FIFO head, else drop the enable and hold the rest
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.grf_we <= 1'b0;
      bus.grf_a3 <= '0;
      bus.grf_wd <= '0;
      bus.grf_pc <= '0;
    end else if (m_req) begin
      bus.grf_we <= 1'b1;
      bus.grf_a3 <= bus.m_a3;
      bus.grf_wd <= bus.m_wd;
      bus.grf_pc <= bus.m_pc;
    end else if (pop) begin
      bus.grf_we <= 1'b1;
      bus.grf_a3 <= head.a3;
      bus.grf_wd <= head.wd;
      bus.grf_pc <= head.pc;
    end else begin
      bus.grf_we <= 1'b0;
    end
  end

  // next head age: cleared on pop or when empty, otherwise saturating increment
  always_comb begin
    age_next = age;
    if (pop || (count == '0))            age_next = '0;
    else if (age < AW'(STARVE_LIMIT))    age_next = age + AW'(1);
  end

  // age and stall flop together so stall_req always matches age >= STARVE_LIMIT
  always_ff @(posedge clk) begin
    if (reset) begin
      age           <= '0;
      bus.stall_req <= 1'b0;
    end else begin
      age           <= age_next;
      bus.stall_req <= (age_next >= AW'(STARVE_LIMIT));
    end
  end

  // pending-write mask over live FIFO entries; $0 never counts as pending
  always_comb begin
    pmask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) pmask[ent_a3[i]] = 1'b1;
    end
    pmask[0] = 1'b0;
  end

  assign bus.pend_mask  = pmask;
  assign bus.fifo_count = count;
  assign bus.mdu_ready  = ready;

endmodule

// File: tb/tb_w_wb_arbiter.sv
// Directed bench for w_wb_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_w_wb_arbiter;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  w_wb_arbiter_if #(.DEPTH(2)) bus ();

  w_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock edge; the ordering rule is checked on the inputs about to be sampled
  task automatic tick();
    logic [31:0] pm;
    pm = bus.pend_mask;
    if (bus.m_we) chk("order_rule", {31'd0, pm[bus.m_a3]}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic grf(input string tag, input logic we, input logic [4:0] a3,
                     input logic [31:0] wd, input logic [31:0] pc);
    chk({tag, "_we"}, {31'd0, bus.grf_we}, {31'd0, we});
    chk({tag, "_a3"}, {27'd0, bus.grf_a3}, {27'd0, a3});
    chk({tag, "_wd"}, bus.grf_wd, wd);
    chk({tag, "_pc"}, bus.grf_pc, pc);
  endtask

  task automatic side(input string tag, input logic [31:0] pm, input logic [1:0] cnt,
                      input logic rdy, input logic stl);
    chk({tag, "_pend"},  bus.pend_mask, pm);
    chk({tag, "_count"}, {30'd0, bus.fifo_count}, {30'd0, cnt});
    chk({tag, "_ready"}, {31'd0, bus.mdu_ready}, {31'd0, rdy});
    chk({tag, "_stall"}, {31'd0, bus.stall_req}, {31'd0, stl});
  endtask

  task automatic pipe(input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    bus.m_we = we; bus.m_a3 = a3; bus.m_wd = wd; bus.m_pc = pc;
  endtask

  task automatic mdu(input logic v, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    bus.mdu_valid = v; bus.mdu_a3 = a3; bus.mdu_wd = wd; bus.mdu_pc = pc;
  endtask

  initial begin
    pipe(0, 0, 0, 0);
    mdu(0, 0, 0, 0);
    tick(); tick();
    grf("rst", 0, 0, 0, 0);
    side("rst", 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("rel_ready", {31'd0, bus.mdu_ready}, 32'd1);

    // pipeline only
    pipe(1, 5, 32'h1234, 32'h100);
    tick();
    grf("pipe", 1, 5, 32'h1234, 32'h100);
    pipe(0, 0, 0, 0);
    tick();
    grf("pipe_idle", 0, 5, 32'h1234, 32'h100);

    // zero-address pipeline write is no write
    pipe(1, 0, 32'hDEAD, 32'h104);
    tick();
    grf("zero_pipe", 0, 5, 32'h1234, 32'h100);
    pipe(0, 0, 0, 0);

    // zero-address MDU result is accepted and discarded
    mdu(1, 0, 32'h5555, 32'h108);
    chk("zero_mdu_ready", {31'd0, bus.mdu_ready}, 32'd1);
    tick();
    mdu(0, 0, 0, 0);
    side("zero_mdu", 0, 0, 1, 0);
    grf("zero_mdu", 0, 5, 32'h1234, 32'h100);

    // MDU alone
    mdu(1, 7, 32'hBEEF, 32'h200);
    tick();
    mdu(0, 0, 0, 0);
    side("mdu_n1", 32'h80, 1, 1, 0);
    grf("mdu_n1", 0, 5, 32'h1234, 32'h100);
    tick();
    grf("mdu_n2", 1, 7, 32'hBEEF, 32'h200);
    side("mdu_n2", 0, 0, 1, 0);

    // fill under continuous pipeline writes
    pipe(1, 1, 32'h11, 32'h300);
    mdu(1, 8, 32'hA8, 32'h308);
    tick();
    grf("fill1", 1, 1, 32'h11, 32'h300);
    side("fill1", 32'h100, 1, 1, 0);
    pipe(1, 2, 32'h22, 32'h304);
    mdu(1, 9, 32'hA9, 32'h30C);
    tick();
    mdu(0, 0, 0, 0);
    grf("fill2", 1, 2, 32'h22, 32'h304);
    side("fill2", 32'h300, 2, 0, 0);
    pipe(1, 3, 32'h33, 32'h310);
    tick();
    side("age2", 32'h300, 2, 0, 0);
    pipe(1, 4, 32'h44, 32'h314);
    tick();
    side("age3", 32'h300, 2, 0, 0);
    pipe(1, 5, 32'h55, 32'h318);
    tick();
    grf("age4", 1, 5, 32'h55, 32'h318);
    side("age4", 32'h300, 2, 0, 1);

    // hazard unit bubbles M: entries drain first-in first
    pipe(0, 0, 0, 0);
    tick();
    grf("drain1", 1, 8, 32'hA8, 32'h308);
    side("drain1", 32'h200, 1, 1, 0);
    tick();
    grf("drain2", 1, 9, 32'hA9, 32'h30C);
    side("drain2", 0, 0, 1, 0);
    tick();
    grf("drain_idle", 0, 9, 32'hA9, 32'h30C);

    // simultaneous push and pop at count 1
    pipe(1, 10, 32'h1010, 32'h400);
    mdu(1, 12, 32'hC12, 32'h404);
    tick();
    side("pp_setup", 32'h1000, 1, 1, 0);
    pipe(0, 0, 0, 0);
    mdu(1, 13, 32'hC13, 32'h408);
    tick();
    mdu(0, 0, 0, 0);
    grf("pp_pop", 1, 12, 32'hC12, 32'h404);
    side("pp_swap", 32'h2000, 1, 1, 0);
    tick();
    grf("pp_next", 1, 13, 32'hC13, 32'h408);
    side("pp_empty", 0, 0, 1, 0);

    // reset with two buffered entries
    pipe(1, 1, 32'h77, 32'h500);
    mdu(1, 14, 32'hE14, 32'h504);
    tick();
    pipe(1, 2, 32'h78, 32'h508);
    mdu(1, 15, 32'hE15, 32'h50C);
    tick();
    side("pre_rst", 32'h0000C000, 2, 0, 0);
    pipe(0, 0, 0, 0);
    mdu(0, 0, 0, 0);
    reset = 1'b1;
    tick();
    grf("mid_rst", 0, 0, 0, 0);
    side("mid_rst", 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("mid_rel_ready", {31'd0, bus.mdu_ready}, 32'd1);
    tick();
    grf("post_rst", 0, 0, 0, 0);
    side("post_rst", 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
